multi_trig_send_arbiter: RTL and testbench
==========================================

// Module: multi_trig_send_arbiter
// PURPOSE
//  Parametrised successor of the UART trigger-to-send handshake generator.
//  Up to CHANNELS trigger inputs are rising-edge detected and latched as pending
//  requests. Requests are arbitrated onto one UART transmitter via a send/nBusy
//  handshake, with an optional send timeout and overrun reporting.
//  Sits between the tick/trigger sources and the UART TX core.
// PARAMETERS
//  CHANNELS        4     number of trigger channels, 1..16
//  PRIORITY_MODE   0     0 = round-robin arbitration, 1 = fixed (lowest index wins)
//  TIMEOUT_CYCLES  1023  max cycles in SEND waiting for nBusyIN low; 0 = no timeout
//  CW (local)            CHANNELS>1 ? clog2(CHANNELS) : 1
// PORTS
//  clkIN        in   1         single clock; all logic on posedge
//  resetIN      in   1         asynchronous, active-high reset
//  trigIN       in   CHANNELS  per-channel trigger level (synchronous to clkIN)
//  nBusyIN      in   1         TX status: 1 = idle, 0 = busy transmitting
//  sendOUT      out  1         send strobe to TX (registered)
//  chanOUT      out  CW        index of the granted channel (registered)
//  pendingOUT   out  CHANNELS  latched, not-yet-granted requests
//  timeoutOUT   out  1         1-cycle pulse: send abandoned, TX never went busy
//  overrunOUT   out  1         1-cycle pulse: edge arrived on an already-pending channel
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; sendOUT, chanOUT, pendingOUT, timeoutOUT,
//   overrunOUT = 0; trig history = 0; rr pointer = 0; timeout counter = 0.
//   Reset mid-SEND drops sendOUT at once; pending requests are lost.
//  Edge detect: rise[i] = trigIN[i] & ~prev[i]; prev <= trigIN each cycle.
//   A trigger held high yields exactly one request; a trigger high at reset release
//   yields one request.
//  Pending: rise[i] sets pending[i]. rise[i] with pending[i] already set ->
//   overrunOUT pulse next cycle; pending stays set (requests do not accumulate).
//   Grant clears pending[g]. rise[g] in the grant cycle keeps pending[g] set,
//   with no overrun.
//  FSM states IDLE, SEND, HOLD:
//   IDLE: if |pending and nBusyIN==1, select g; chanOUT<=g, sendOUT<=1,
//         clear pending[g], counter<=0 -> SEND. Otherwise stay.
//   SEND: sendOUT held 1, counter++. If nBusyIN==0: sendOUT<=0 -> HOLD.
//         Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: sendOUT<=0,
//         timeoutOUT<=1 for one cycle -> IDLE (request dropped, rr still advances).
//         nBusyIN low wins over timeout in the same cycle.
//   HOLD: wait for nBusyIN==1 -> IDLE. No new grant until the TX is idle again.
//  Latency: trigIN first sampled high at edge E -> pendingOUT high after E;
//   sendOUT/chanOUT valid after E+1 (IDLE, TX idle). Minimum grant-to-grant
//   spacing is 3 cycles.
//  Arbitration: round-robin scans ptr, ptr+1, .. mod CHANNELS; after each grant
//   ptr <= (g+1) mod CHANNELS. PRIORITY_MODE=1 ignores ptr.
//  chanOUT stays stable from grant until the next grant.
//  CHANNELS=1: chanOUT constant 0.
//  Counter width = clog2(TIMEOUT_CYCLES+1).
// TESTING
//  1 Single req: trig[0] rises at E, nBusy=1 -> sendOUT=1, chan=0 after E+1;
//    nBusy=0 two cycles later -> sendOUT=0 next edge; nBusy=1 -> back to IDLE.
//  2 RR: trig[3:0]=4'b1111 in one cycle, TX acks each send -> grant order 0,1,2,3.
//    Then trig[0] and trig[2] together -> grant 0 first (ptr=0).
//  3 PRIORITY_MODE=1: first grant 1 with pending {1,3}; raise trig[0] during the
//    send -> next grants 0, then 3.
//  4 TIMEOUT_CYCLES=8, nBusy held 1 -> sendOUT high exactly 8 cycles, one
//    timeoutOUT pulse, pending[g]=0, IDLE.
//  5 Overrun: trig[1] pulses twice while nBusy=0 (TX busy elsewhere) -> one
//    overrunOUT pulse, one send on ch 1. trig[1] held high 50 cycles -> one send.
//  6 Async reset mid-SEND -> sendOUT, pendingOUT=0 without a clock edge;
//    no send after reset release unless a new edge occurs.

Source files
------------

// File: rtl/multi_trig_send_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// multi_trig_send_arbiter
// Collects rising edges from up to CHANNELS trigger inputs as pending requests
// and hands them, one at a time, to a single UART transmitter through a
// send/nBusy handshake. A send that is never acknowledged by the TX going
// busy can be abandoned after TIMEOUT_CYCLES. A second edge on a channel that
// is already pending is reported as an overrun.
//
// Ports
//   clkIN       in   1         clock, all logic on the rising edge
//   resetIN     in   1         asynchronous active-high reset
//   trigIN      in   CHANNELS  per-channel trigger level
//   nBusyIN     in   1         TX status, 1 = idle, 0 = transmitting
//   sendOUT     out  1         send strobe to the TX, held until TX goes busy
//   chanOUT     out  CW        index of the most recently granted channel
//   pendingOUT  out  CHANNELS  latched requests not yet granted
//   timeoutOUT  out  1         one-cycle pulse when a send is abandoned
//   overrunOUT  out  1         one-cycle pulse when an edge hits a pending channel
// ---------------------------------------------------------------------------
module multi_trig_send_arbiter #(
    parameter int CHANNELS       = 4,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clkIN,
    input  logic                resetIN,
    input  logic [CHANNELS-1:0] trigIN,
    input  logic                nBusyIN,
    output logic                sendOUT,
    output logic [CW-1:0]       chanOUT,
    output logic [CHANNELS-1:0] pendingOUT,
    output logic                timeoutOUT,
    output logic                overrunOUT
);

    // A zero timeout still needs a legal one-bit counter.
    localparam int CNTW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CHANNELS-1:0] prev_r;
    logic [CHANNELS-1:0] pending_r;
    logic [CHANNELS-1:0] pending_s;
    logic [CW-1:0]       ptr_r;
    logic [CW-1:0]       ptr_s;
    logic [CNTW-1:0]     cnt_r;
    logic [CNTW-1:0]     cnt_s;
    logic                send_r;
    logic                send_s;
    logic [CW-1:0]       chan_r;
    logic [CW-1:0]       chan_s;
    logic                timeout_r;
    logic                timeout_s;
    logic                overrun_r;
    logic                overrun_s;

    logic [CHANNELS-1:0] rise_s;
    logic [CHANNELS-1:0] grant_mask_s;
    logic [CHANNELS-1:0] take_mask_s;
    logic [CW-1:0]       grant_idx_s;
    logic                grant_found_s;
    logic                take_s;

    assign sendOUT    = send_r;
    assign chanOUT    = chan_r;
    assign pendingOUT = pending_r;
    assign timeoutOUT = timeout_r;
    assign overrunOUT = overrun_r;

    // Arbiter: the first pass only considers channels at or above the round-robin
    // pointer, the second pass wraps around to the rest; fixed mode ignores the pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_mask_s  = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_found_s && pending_r[i] &&
                    ((p == 1) || (PRIORITY_MODE != 0) || (i >= int'(ptr_r)))) begin
                    grant_found_s   = 1'b1;
                    grant_idx_s     = CW'(i);
                    grant_mask_s    = '0;
                    grant_mask_s[i] = 1'b1;
                end else begin
                    grant_found_s = grant_found_s;
                end
            end
        end
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_s   = state_r;
        send_s    = send_r;
        chan_s    = chan_r;
        cnt_s     = cnt_r;
        ptr_s     = ptr_r;
        timeout_s = 1'b0;
        take_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s && nBusyIN) begin
                    take_s  = 1'b1;
                    chan_s  = grant_idx_s;
                    send_s  = 1'b1;
                    cnt_s   = '0;
                    state_s = ST_SEND;
                    if (grant_idx_s == CW'(CHANNELS - 1)) begin
                        ptr_s = '0;
                    end else begin
                        ptr_s = grant_idx_s + CW'(1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                cnt_s = cnt_r + CNTW'(1);
                // TX going busy takes precedence over an expiring timeout.
                if (!nBusyIN) begin
                    send_s  = 1'b0;
                    state_s = ST_HOLD;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNTW'(TIMEOUT_CYCLES - 1))) begin
                    send_s    = 1'b0;
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_HOLD: begin
                send_s = 1'b0;
                if (nBusyIN) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                send_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request bookkeeping: a fresh edge on the channel being granted re-arms it
    // without counting as an overrun.
    always_comb begin
        rise_s      = trigIN & ~prev_r;
        take_mask_s = take_s ? grant_mask_s : {CHANNELS{1'b0}};
        pending_s   = (pending_r & ~take_mask_s) | rise_s;
        overrun_s   = |(rise_s & pending_r & ~take_mask_s);
    end

    // FSM state register.
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clkIN or posedge resetIN) begin
        if (resetIN) begin
            prev_r    <= '0;
            pending_r <= '0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            send_r    <= 1'b0;
            chan_r    <= '0;
            timeout_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            prev_r    <= trigIN;
            pending_r <= pending_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            send_r    <= send_s;
            chan_r    <= chan_s;
            timeout_r <= timeout_s;
            overrun_r <= overrun_s;
        end
    end

endmodule

// File: tb/tb_multi_trig_send_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes the expected granted channel into a
// per-instance queue, the negedge monitor pops and compares on every rising
// sendOUT. Instance a: round-robin, b: fixed priority, c: 8-cycle timeout.
module tb_multi_trig_send_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] trig_a, trig_b, trig_c;
    logic       nb_a, nb_b, nb_c;
    logic       send_a, send_b, send_c;
    logic [1:0] chan_a, chan_b, chan_c;
    logic [3:0] pend_a, pend_b, pend_c;
    logic       to_a, to_b, to_c;
    logic       ov_a, ov_b, ov_c;

    int n_checks = 0;
    int n_fail   = 0;
    int q_a[$];
    int q_b[$];
    int q_c[$];
    int grants_a = 0, grants_b = 0, grants_c = 0;
    int ov_cnt_a = 0, to_cnt_c = 0;
    logic send_a_d = 1'b0, send_b_d = 1'b0, send_c_d = 1'b0;

    multi_trig_send_arbiter #(.CHANNELS(4), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(1023)) dut_a (
        .clkIN(clk), .resetIN(rst), .trigIN(trig_a), .nBusyIN(nb_a), .sendOUT(send_a),
        .chanOUT(chan_a), .pendingOUT(pend_a), .timeoutOUT(to_a), .overrunOUT(ov_a));

    multi_trig_send_arbiter #(.CHANNELS(4), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(1023)) dut_b (
        .clkIN(clk), .resetIN(rst), .trigIN(trig_b), .nBusyIN(nb_b), .sendOUT(send_b),
        .chanOUT(chan_b), .pendingOUT(pend_b), .timeoutOUT(to_b), .overrunOUT(ov_b));

    multi_trig_send_arbiter #(.CHANNELS(4), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut_c (
        .clkIN(clk), .resetIN(rst), .trigIN(trig_c), .nBusyIN(nb_c), .sendOUT(send_c),
        .chanOUT(chan_c), .pendingOUT(pend_c), .timeoutOUT(to_c), .overrunOUT(ov_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one pop per rising send strobe.
    always @(negedge clk) begin
        if (send_a && !send_a_d) begin
            grants_a <= grants_a + 1;
            if (q_a.size() == 0) check("a_unexpected_grant", {30'd0, chan_a}, 32'hFFFF_FFFF);
            else check("a_chan", {30'd0, chan_a}, q_a.pop_front());
        end
        if (send_b && !send_b_d) begin
            grants_b <= grants_b + 1;
            if (q_b.size() == 0) check("b_unexpected_grant", {30'd0, chan_b}, 32'hFFFF_FFFF);
            else check("b_chan", {30'd0, chan_b}, q_b.pop_front());
        end
        if (send_c && !send_c_d) begin
            grants_c <= grants_c + 1;
            if (q_c.size() == 0) check("c_unexpected_grant", {30'd0, chan_c}, 32'hFFFF_FFFF);
            else check("c_chan", {30'd0, chan_c}, q_c.pop_front());
        end
        if (ov_a) ov_cnt_a <= ov_cnt_a + 1;
        if (to_c) to_cnt_c <= to_cnt_c + 1;
        send_a_d <= send_a;
        send_b_d <= send_b;
        send_c_d <= send_c;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_send(input int sel);
        case (sel)
            0:       return send_a;
            1:       return send_b;
            default: return send_c;
        endcase
    endfunction

    task automatic set_nb(input int sel, input logic v);
        case (sel)
            0:       nb_a = v;
            1:       nb_b = v;
            default: nb_c = v;
        endcase
    endtask

    task automatic wait_send(input int sel);
        int k = 0;
        while (cur_send(sel) == 1'b0 && k < 20) begin
            tick();
            k++;
        end
        check("wait_send", {31'd0, cur_send(sel)}, 32'd1);
    endtask

    // TX acknowledges: goes busy two cycles into the send, then idle again.
    task automatic finish_send(input int sel);
        tick();
        tick();
        set_nb(sel, 1'b0);
        tick();
        check("send_drop", {31'd0, cur_send(sel)}, 32'd0);
        set_nb(sel, 1'b1);
        tick();
    endtask

    task automatic serve(input int sel, input int n);
        for (int j = 0; j < n; j++) begin
            wait_send(sel);
            finish_send(sel);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        trig_a = 4'd0; trig_b = 4'd0; trig_c = 4'd0;
        nb_a   = 1'b1; nb_b   = 1'b1; nb_c   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int g0;
        int o0;
        int len;
        rst = 1'b1;
        trig_a = 4'd0; trig_b = 4'd0; trig_c = 4'd0;
        nb_a = 1'b1; nb_b = 1'b1; nb_c = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_send",    {31'd0, send_a}, 32'd0);
        check("rst_chan",    {30'd0, chan_a}, 32'd0);
        check("rst_pending", {28'd0, pend_a}, 32'd0);
        check("rst_timeout", {31'd0, to_a},   32'd0);
        check("rst_overrun", {31'd0, ov_a},   32'd0);
        rst = 1'b0;
        tick();

        // 1: single request
        trig_a = 4'b0001;
        q_a.push_back(0);
        tick();
        check("t1_pending", {28'd0, pend_a}, 32'd1);
        check("t1_no_send_yet", {31'd0, send_a}, 32'd0);
        tick();
        check("t1_send", {31'd0, send_a}, 32'd1);
        check("t1_pending_clr", {28'd0, pend_a}, 32'd0);
        finish_send(0);
        check("t1_idle_send", {31'd0, send_a}, 32'd0);
        trig_a = 4'd0;
        tick();

        // 2: round-robin order 0,1,2,3 then 0,2
        do_reset();
        tick();
        trig_a = 4'b1111;
        q_a.push_back(0); q_a.push_back(1); q_a.push_back(2); q_a.push_back(3);
        tick();
        trig_a = 4'b0000;
        serve(0, 4);
        trig_a = 4'b0101;
        q_a.push_back(0); q_a.push_back(2);
        tick();
        trig_a = 4'b0000;
        serve(0, 2);
        check("t2_pending_empty", {28'd0, pend_a}, 32'd0);

        // 3: fixed priority with late request on channel 0
        trig_b = 4'b1010;
        q_b.push_back(1);
        tick();
        trig_b = 4'b0000;
        wait_send(1);
        check("t3_pending_after_g1", {28'd0, pend_b}, 32'd8);
        trig_b = 4'b0001;
        q_b.push_back(0); q_b.push_back(3);
        finish_send(1);
        serve(1, 2);
        trig_b = 4'b0000;
        check("t3_grants", grants_b, 32'd3);

        // 4: timeout after exactly 8 cycles of send
        trig_c = 4'b0100;
        q_c.push_back(2);
        wait_send(2);
        len = 0;
        while (send_c == 1'b1 && len < 30) begin
            len++;
            tick();
        end
        check("t4_send_len", len, 32'd8);
        check("t4_timeout_pulse", {31'd0, to_c}, 32'd1);
        trig_c = 4'b0000;
        tick();
        tick();
        check("t4_timeout_count", to_cnt_c, 32'd1);
        check("t4_pending", {28'd0, pend_c}, 32'd0);
        check("t4_idle", {31'd0, send_c}, 32'd0);
        check("t4_grants", grants_c, 32'd1);

        // 5: overrun while TX busy, then held trigger
        o0 = ov_cnt_a;
        nb_a = 1'b0;
        trig_a = 4'b0010; tick();
        trig_a = 4'b0000; tick();
        trig_a = 4'b0010; tick();
        check("t5_overrun_pulse", {31'd0, ov_a}, 32'd1);
        check("t5_pending", {28'd0, pend_a}, 32'd2);
        trig_a = 4'b0000; tick();
        check("t5_overrun_end", {31'd0, ov_a}, 32'd0);
        g0 = grants_a;
        q_a.push_back(1);
        nb_a = 1'b1;
        serve(0, 1);
        check("t5_one_send", grants_a - g0, 32'd1);
        check("t5_chan_stable", {30'd0, chan_a}, 32'd1);
        g0 = grants_a;
        trig_a = 4'b0010;
        q_a.push_back(1);
        serve(0, 1);
        for (int j = 0; j < 40; j++) tick();
        trig_a = 4'b0000;
        tick();
        check("t5_held_one_send", grants_a - g0, 32'd1);
        check("t5_overrun_total", ov_cnt_a - o0, 32'd1);

        // 6: async reset in the middle of a send (ptr=2 -> channel 3 first)
        trig_a = 4'b1001;
        q_a.push_back(3);
        wait_send(0);
        check("t6_pending_before", {28'd0, pend_a}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_send", {31'd0, send_a}, 32'd0);
        check("t6_async_pending", {28'd0, pend_a}, 32'd0);
        trig_a = 4'b0000;
        tick();
        tick();
        g0 = grants_a;
        rst = 1'b0;
        for (int j = 0; j < 10; j++) tick();
        check("t6_no_send_after", grants_a - g0, 32'd0);
        check("t6_pending_after", {28'd0, pend_a}, 32'd0);

        check("q_a_empty", q_a.size(), 32'd0);
        check("q_b_empty", q_b.size(), 32'd0);
        check("q_c_empty", q_c.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
